uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Parses 5-byte UART command frames, runs one register-bus access and returns a
// paced 4-byte response. Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | hunting for the 0x55 header, busy low
// GET_CMD  | waiting for CMD byte
// GET_ADDR | waiting for ADDR byte
// GET_DATA | waiting for DATA byte
// GET_CSUM | waiting for CSUM byte, decides status and strobe
// EXEC     | bus strobe cycle (reg_wr or reg_rd, or none on error)
// RD_WAIT  | capture reg_rdata
// TX_LOAD  | tx_enable pulse for response byte idx
// TX_GAP   | pacing delay before the next response byte
module uart_cmd_responder #(
  parameter logic [31:0] CLK_FREQ      = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD     = 32'd115200,
  parameter int unsigned TX_GAP_BITS   = 11,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [31:0] BIT_CYC = CLK_FREQ / UART_BAUD;
  localparam logic [31:0] TX_GAP  = 32'(TX_GAP_BITS) * BIT_CYC;
  localparam logic [7:0]  CMD_HDR = 8'h55;
  localparam logic [7:0]  RSP_HDR = 8'h5A;
  localparam logic [7:0]  CMD_WR  = 8'h01;
  localparam logic [7:0]  CMD_RD  = 8'h02;

  typedef enum logic [3:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CSUM, EXEC, RD_WAIT, TX_LOAD, TX_GAP_S
  } state_t;

  state_t      state;
  logic [7:0]  cmd;
  logic [1:0]  status;
  logic [7:0]  resp_data;
  logic [1:0]  idx;
  logic [31:0] gap_cnt;
  logic [7:0]  frame_sum;
  logic        csum_ok;
  logic [7:0]  next_byte;

  // reg_addr and reg_wdata double as the ADDR/DATA frame latches
  assign frame_sum = cmd + reg_addr + reg_wdata;
  assign csum_ok   = (frame_sum == rx_data);

  always_comb begin
    next_byte = RSP_HDR;
    case (idx + 2'd1)
      2'd1:    next_byte = {6'd0, status};
      2'd2:    next_byte = resp_data;
      2'd3:    next_byte = {6'd0, status} + resp_data;
      default: next_byte = RSP_HDR;
    endcase
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_BYTES) * 32'd10 * BIT_CYC;
  logic [31:0] to_cnt;
  logic        in_frame;
  assign in_frame = (state == GET_CMD) || (state == GET_ADDR) ||
                    (state == GET_DATA) || (state == GET_CSUM);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_data   <= 8'd0;
      tx_enable <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      cmd       <= 8'd0;
      status    <= 2'd0;
      resp_data <= 8'd0;
      idx       <= 2'd0;
      gap_cnt   <= 32'd0;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt    <= 32'd0;
`endif
    end else begin
      tx_enable <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done && rx_data == CMD_HDR) begin
            state <= GET_CMD;
            busy  <= 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
            to_cnt <= TIMEOUT_CYC - 32'd1;
`endif
          end
        end
        GET_CMD: if (rx_done) begin
          cmd   <= rx_data;
          state <= GET_ADDR;
        end
        GET_ADDR: if (rx_done) begin
          reg_addr <= rx_data;
          state    <= GET_DATA;
        end
        GET_DATA: if (rx_done) begin
          reg_wdata <= rx_data;
          state     <= GET_CSUM;
        end
        GET_CSUM: if (rx_done) begin
          // checksum error outranks an unknown command
          if (!csum_ok)                         status <= 2'd1;
          else if (cmd != CMD_WR && cmd != CMD_RD) status <= 2'd2;
          else                                  status <= 2'd0;
          resp_data <= (csum_ok && cmd == CMD_WR) ? reg_wdata : 8'd0;
          reg_wr    <= csum_ok && (cmd == CMD_WR);
          reg_rd    <= csum_ok && (cmd == CMD_RD);
          state     <= EXEC;
        end
        EXEC: begin
          if (reg_rd) begin
            state <= RD_WAIT;
          end else begin
            idx       <= 2'd0;
            tx_data   <= RSP_HDR;
            tx_enable <= 1'b1;
            state     <= TX_LOAD;
          end
        end
        RD_WAIT: begin
          resp_data <= reg_rdata;
          idx       <= 2'd0;
          tx_data   <= RSP_HDR;
          tx_enable <= 1'b1;
          state     <= TX_LOAD;
        end
        TX_LOAD: begin
          gap_cnt <= TX_GAP - 32'd1;
          state   <= TX_GAP_S;
        end
        TX_GAP_S: begin
          if (gap_cnt == 32'd0) begin
            if (idx == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              idx       <= idx + 2'd1;
              tx_data   <= next_byte;
              tx_enable <= 1'b1;
              state     <= TX_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      if (in_frame) begin
        if (rx_done) begin
          to_cnt <= TIMEOUT_CYC - 32'd1;
        end else if (to_cnt == 32'd0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          to_cnt <= to_cnt - 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed and random frames checked
// against a frame-level reference model and a simple register-bus slave.
module tb_uart_cmd_responder;

  localparam int CLK_FREQ      = 1_000_000;
  localparam int UART_BAUD     = 100_000;
  localparam int TX_GAP_BITS   = 11;
  localparam int TIMEOUT_BYTES = 4;
  localparam int BIT_CYC       = CLK_FREQ / UART_BAUD;
  localparam int TX_GAP        = TX_GAP_BITS * BIT_CYC;
  localparam int TIMEOUT_CYC   = TIMEOUT_BYTES * 10 * BIT_CYC;
  localparam int RESP_WAIT     = 4 * (TX_GAP + 1) + 20;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int excl_viol = 0;

  logic [7:0]  slave_mem [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  tx_q [$];
  int          tx_t [$];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  uart_cmd_responder #(
    .CLK_FREQ(32'(CLK_FREQ)), .UART_BAUD(32'(UART_BAUD)),
    .TX_GAP_BITS(TX_GAP_BITS), .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_enable(tx_enable), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // bus slave: read data is only meaningful the cycle after reg_rd
  always @(posedge clk_in) begin
    if (cyc == 0) begin
      for (int a = 0; a < 256; a++) slave_mem[a] <= 8'(a * 7 + 1);
    end else if (reg_wr) begin
      slave_mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_rd ? slave_mem[reg_addr] : 8'($urandom);
  end

  always @(negedge clk_in) begin
    if (rx_done) last_rx_cyc = cyc;
    if (tx_enable) begin
      tx_q.push_back(tx_data);
      tx_t.push_back(cyc);
    end
    if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_q.push_back(reg_addr);
    if (reg_wr && reg_rd) excl_viol++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_in); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk_in); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk_in);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] csum,
                           input int garbage, input bit intrude, input string tag);
    int b_tx, b_wr, b_rd, rx_c, n_tx;
    bit ok, is_wr, is_rd;
    logic [7:0] st, rd, g;
    logic [7:0] exp_b [4];
    b_tx = tx_q.size();
    b_wr = wr_q.size();
    b_rd = rd_q.size();
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'h55) g = 8'h12;
      send_byte(g);
    end
    send_byte(8'h55);
    send_byte(cmd);
    send_byte(addr);
    send_byte(data);
    send_byte(csum);
    rx_c = last_rx_cyc;
    chk({tag, "_busy_hi"}, int'(busy), 1);

    ok    = ((int'(cmd) + int'(addr) + int'(data)) % 256) == int'(csum);
    is_wr = ok && cmd == 8'h01;
    is_rd = ok && cmd == 8'h02;
    st    = !ok ? 8'h01 : (!is_wr && !is_rd) ? 8'h02 : 8'h00;
    rd    = is_wr ? data : is_rd ? model_mem[addr] : 8'h00;
    if (is_wr) model_mem[addr] = data;
    exp_b = '{8'h5A, st, rd, 8'(st + rd)};

    if (intrude) begin
      repeat (20) @(posedge clk_in);
      send_byte(8'h55); send_byte(8'h01); send_byte(addr ^ 8'h01);
      send_byte(8'hEE); send_byte(8'(8'h01 + (addr ^ 8'h01) + 8'hEE));
    end
    repeat (RESP_WAIT) @(posedge clk_in);
    #1;

    n_tx = tx_q.size() - b_tx;
    chk({tag, "_tx_count"}, n_tx, 4);
    if (n_tx == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("%s_tx_byte%0d", tag, i), int'(tx_q[b_tx + i]), int'(exp_b[i]));
      for (int i = 0; i < 3; i++) chk($sformatf("%s_tx_gap%0d", tag, i), tx_t[b_tx + i + 1] - tx_t[b_tx + i], TX_GAP + 1);
      chk({tag, "_latency"}, tx_t[b_tx] - rx_c, is_rd ? 3 : 2);
    end
    chk({tag, "_wr_count"}, wr_q.size() - b_wr, int'(is_wr));
    if (is_wr && wr_q.size() > b_wr) chk({tag, "_wr_bus"}, int'(wr_q[b_wr]), int'({addr, data}));
    chk({tag, "_rd_count"}, rd_q.size() - b_rd, int'(is_rd));
    if (is_rd && rd_q.size() > b_rd) chk({tag, "_rd_addr"}, int'(rd_q[b_rd]), int'(addr));
    chk({tag, "_busy_lo"}, int'(busy), 0);
    chk({tag, "_strobe_excl"}, excl_viol, 0);
  endtask

  initial begin : main
    int b_tx, b_wr, b_rd, rx_c, kind;
    logic [7:0] c, a, d, s;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 7 + 1);

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_outputs", int'({tx_data, tx_enable, reg_addr, reg_wdata, reg_wr, reg_rd, busy}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_in);

    run_frame(8'h01, 8'h03, 8'hA5, 8'hA9, 0, 1'b0, "wr_basic");
    run_frame(8'h01, 8'h07, 8'h3C, 8'h44, 0, 1'b0, "wr_07");
    run_frame(8'h02, 8'h07, 8'h00, 8'h09, 0, 1'b0, "rd_07");
    run_frame(8'h01, 8'h03, 8'hA5, 8'h00, 0, 1'b0, "bad_csum");
    run_frame(8'h07, 8'h00, 8'h00, 8'h07, 0, 1'b0, "bad_cmd");
    run_frame(8'h01, 8'h55, 8'h55, 8'hAB, 0, 1'b0, "data_55");
    begin
      send_byte(8'h12);
      send_byte(8'h34);
      run_frame(8'h01, 8'h10, 8'h5B, 8'h6C, 0, 1'b0, "garbage");
    end
    run_frame(8'h02, 8'h03, 8'h11, 8'h16, 0, 1'b1, "intrude");

    // reset in the middle of a frame
    b_tx = tx_q.size();
    b_wr = wr_q.size();
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h03);
    #3 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", int'({tx_data, tx_enable, reg_addr, reg_wdata, reg_wr, reg_rd, busy}), 0);
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    chk("midframe_reset_no_tx", tx_q.size() - b_tx, 0);
    chk("midframe_reset_no_wr", wr_q.size() - b_wr, 0);
    run_frame(8'h01, 8'h20, 8'h77, 8'h98, 0, 1'b0, "after_reset");

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      case (kind)
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h01;
        default: begin
          c = 8'($urandom);
          if (c == 8'h01 || c == 8'h02) c = 8'h80;
        end
      endcase
      s = 8'(c + a + d);
      if (kind == 2) s = s ^ 8'(1 << $urandom_range(0, 7));
      run_frame(c, a, d, s, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $sformatf("rand%0d", n));
    end

    // stall after two bytes of a frame
    b_tx = tx_q.size();
    b_wr = wr_q.size();
    b_rd = rd_q.size();
    send_byte(8'h55);
    send_byte(8'h01);
    rx_c = last_rx_cyc;
    chk("stall_busy_after_hdr", int'(busy), 1);
    while (cyc < rx_c + TIMEOUT_CYC - 5) @(posedge clk_in);
    #1;
    chk("stall_busy_before_limit", int'(busy), 1);
    while (cyc < rx_c + TIMEOUT_CYC + 5) @(posedge clk_in);
    #1;
`ifdef UART_CMD_TIMEOUT_EN
    chk("timeout_busy_lo", int'(busy), 0);
`else
    chk("no_timeout_busy_hi", int'(busy), 1);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
`endif
    chk("stall_no_tx", tx_q.size() - b_tx, 0);
    chk("stall_no_strobe", (wr_q.size() - b_wr) + (rd_q.size() - b_rd), 0);
    run_frame(8'h02, 8'h20, 8'h00, 8'h22, 0, 1'b0, "after_stall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
